// File: rtl/rx_pkg.sv
// Shared constants and types for the receive-side instruction fetch stage.
package rx_pkg;

  // Byte positions inside a 64-bit program word.
  localparam int OPC = 0;
  localparam int DST = 1;
  localparam int SRC = 2;
  localparam int MOD = 3;
  localparam int IMM = 4;

  localparam int INT_OP_LIMIT_DEF = 120;
  localparam int PROG_LEN_DEF     = 256;
  localparam int REG_IDX_W        = 3;
  localparam int IMM_MAX_W        = 32;
  localparam int IDX_W            = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rx_state_t;

  typedef struct packed {
    logic [7:0]           opcode;
    logic [6:0]           int_op;
    logic                 is_int;
    logic [REG_IDX_W-1:0] dst;
    logic [REG_IDX_W-1:0] src;
    logic                 src_eq_dst;
    logic [7:0]           mod;
    logic                 mem_l1;
    logic [IMM_MAX_W-1:0] imm;
    logic [IDX_W-1:0]     idx;
    logic                 last;
  } rx_instr_fields_t;

  function automatic logic [7:0] instr_byte(input logic [63:0] w, input int b);
    return w[b*8 +: 8];
  endfunction

endpackage

// File: rtl/rx_skid_buf.sv
// Two-entry FIFO holding pre-split instruction fields; head entry drives the outputs directly.
// Latency: an entry pushed in cycle N is visible at the head in cycle N+1.
// Backpressure: pushes are dropped when full; occ_nxt lets the owner register its ready.
module rx_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         pop_vld,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat,
  output logic [1:0]   occ_nxt
);

  logic [W-1:0] ent0_q;
  logic [W-1:0] ent1_q;
  logic [1:0]   occ_q;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop_rdy && (occ_q != 2'd0);
  assign do_push = push_vld && (occ_q != 2'd2);
  assign occ_nxt = occ_q + {1'b0, do_push} - {1'b0, do_pop};
  assign pop_vld = (occ_q != 2'd0);
  assign pop_dat = ent0_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= 2'd0;
      ent0_q <= '0;
      ent1_q <= '0;
    end else begin
      occ_q <= occ_nxt;
      if (do_pop) begin
        // A full buffer cannot take a push, so only the one-entry case refills the head.
        if (occ_q == 2'd2) begin
          ent0_q <= ent1_q;
        end else if (do_push) begin
          ent0_q <= push_dat;
        end
      end else if (do_push) begin
        if (occ_q == 2'd0) begin
          ent0_q <= push_dat;
        end else begin
          ent1_q <= push_dat;
        end
      end
    end
  end

endmodule

// File: rtl/rx_instr_fetch.sv
// Fetch stage ahead of decode_int: counts program words, splits and classifies fields.
// Latency: a word accepted in cycle N is presented in cycle N+1; 1 word/cycle sustained.
// Backpressure: 2-entry buffer absorbs stalls; in_ready_o is registered from next occupancy.
module rx_instr_fetch
  import rx_pkg::*;
#(
  parameter int PROG_LEN     = PROG_LEN_DEF,
  parameter int INT_OP_LIMIT = INT_OP_LIMIT_DEF,
  parameter int IMM_W        = IMM_MAX_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [63:0]          instr_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [7:0]           opcode_o,
  output logic [6:0]           int_op_o,
  output logic                 is_int_o,
  output logic [2:0]           dst_o,
  output logic [2:0]           src_o,
  output logic                 src_eq_dst_o,
  output logic [7:0]           mod_o,
  output logic                 mem_l1_o,
  output logic [IMM_W-1:0]     imm_o,
  output logic [7:0]           idx_o,
  output logic                 last_o,
  output logic                 done_o
);

  localparam int CNT_W = (PROG_LEN > 1) ? $clog2(PROG_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PROG_LEN - 1);

  rx_state_t        state_q;
  rx_state_t        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q;
  logic             push;
  logic             pop;
  logic             head_vld;
  logic [1:0]       occ_nxt;
  rx_instr_fields_t enq_fields;
  rx_instr_fields_t head;
  logic [7:0]       opc_b;
  logic [7:0]       dst_b;
  logic [7:0]       src_b;
  logic [7:0]       mod_b;

  assign push = in_valid_i && in_ready_q;
  assign pop  = head_vld && out_ready_i;

  assign opc_b = instr_byte(instr_i, OPC);
  assign dst_b = instr_byte(instr_i, DST);
  assign src_b = instr_byte(instr_i, SRC);
  assign mod_b = instr_byte(instr_i, MOD);

  always_comb begin
    enq_fields            = '0;
    enq_fields.opcode     = opc_b;
    enq_fields.is_int     = ({24'd0, opc_b} < 32'(INT_OP_LIMIT));
    // Non-integer opcodes are zeroed so decode_int sees op 0; consumers gate on is_int.
    enq_fields.int_op     = enq_fields.is_int ? opc_b[6:0] : 7'd0;
    enq_fields.dst        = dst_b[REG_IDX_W-1:0];
    enq_fields.src        = src_b[REG_IDX_W-1:0];
    enq_fields.src_eq_dst = (dst_b[REG_IDX_W-1:0] == src_b[REG_IDX_W-1:0]);
    enq_fields.mod        = mod_b;
    enq_fields.mem_l1     = |mod_b[1:0];
    enq_fields.imm        = instr_i[IMM*8 +: IMM_MAX_W];
    enq_fields.idx        = IDX_W'(cnt_q);
    enq_fields.last       = (cnt_q == LAST_CNT);
  end

  rx_skid_buf #(
    .W($bits(rx_instr_fields_t))
  ) u_buf (
    .clk      (clk_i),
    .rst      (rst_i),
    .push_vld (push),
    .push_dat (enq_fields),
    .pop_vld  (head_vld),
    .pop_rdy  (out_ready_i),
    .pop_dat  (head),
    .occ_nxt  (occ_nxt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_RUN;
      ST_RUN:   if (push && (cnt_q == LAST_CNT)) state_d = ST_DRAIN;
      ST_DRAIN: if (occ_nxt == 2'd0) state_d = ST_DONE;
      ST_DONE:  if (start_i) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == ST_RUN) && (occ_nxt != 2'd2);
      if (start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE))) begin
        cnt_q <= '0;
      end else if (push) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign in_ready_o   = in_ready_q;
  assign out_valid_o  = head_vld;
  assign done_o       = (state_q == ST_DONE);
  assign opcode_o     = head.opcode;
  assign int_op_o     = head.int_op;
  assign is_int_o     = head.is_int;
  assign dst_o        = head.dst;
  assign src_o        = head.src;
  assign src_eq_dst_o = head.src_eq_dst;
  assign mod_o        = head.mod;
  assign mem_l1_o     = head.mem_l1;
  assign imm_o        = head.imm[IMM_W-1:0];
  assign idx_o        = head.idx;
  assign last_o       = head.last;

  logic unused_pop;
  assign unused_pop = pop;

endmodule
